// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle between the multicycle control unit and the datapath.
// Optional retired-instruction counter port present when CTRL_PERF_CNT_EN is defined.
interface multicycle_control_unit_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  pc_src;
    logic [2:0]  Rd;
    logic [2:0]  Rs1;
    logic [2:0]  Rs2;
    logic        branch;
    logic        m;
    logic        store;
    logic [2:0]  ALUOp;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        RegWrite;
    logic [2:0]  WriteReg;
    logic        illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired;
`endif

    modport master (
        input  instr, mem_ready, zero,
        output IRWrite, PCWrite, pc_src, Rd, Rs1, Rs2, branch, m, store,
               ALUOp, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, WriteReg, illegal
`ifdef CTRL_PERF_CNT_EN
        , output retired
`endif
    );

    modport slave (
        output instr, mem_ready, zero,
        input  IRWrite, PCWrite, pc_src, Rd, Rs1, Rs2, branch, m, store,
               ALUOp, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, WriteReg, illegal
`ifdef CTRL_PERF_CNT_EN
        , input retired
`endif
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for the 16-bit, 8-register core.
// Define CTRL_PERF_CNT_EN to add the retired-instruction counter.
//   state    | meaning
//   S_FETCH  | request instruction, latch IR and bump PC on mem_ready
//   S_DECODE | register fields valid; JMP and illegal opcodes resolve here
//   S_EXEC   | ALU operation; branches resolve here
//   S_MEM    | data access held until mem_ready or timeout
//   S_WB     | register write-back
module multicycle_control_unit #(
    parameter int OPW         = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_unit_if.master   bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPW-1:0] OP_AND  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(3);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(4);
    localparam logic [OPW-1:0] OP_LW   = OPW'(5);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(7);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(8);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(9);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_ir;
    logic [CW-1:0]   r_wait;

    logic [OPW-1:0]  w_op;
    logic            w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_jmp, w_is_illegal;
    logic            w_is_branch, w_timeout;
    logic            w_unused_ir;

    assign w_op         = r_ir[15 -: OPW];
    assign w_is_lw      = (w_op == OP_LW);
    assign w_is_sw      = (w_op == OP_SW);
    assign w_is_beq     = (w_op == OP_BEQ);
    assign w_is_bne     = (w_op == OP_BNE);
    assign w_is_jmp     = (w_op == OP_JMP);
    assign w_is_illegal = (w_op > OP_JMP);
    assign w_is_branch  = w_is_beq | w_is_bne;
    assign w_timeout    = (r_wait == CW'(MEM_TIMEOUT));
    assign w_unused_ir  = &{1'b0, r_ir[2:0]};

    // IR is cleared by reset, so the register fields read 0 while rst_n is low.
    assign bus.Rd  = r_ir[11:9];
    assign bus.Rs1 = r_ir[8:6];
    assign bus.Rs2 = r_ir[5:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.mem_ready)
                r_ir <= bus.instr;
            if (r_state == S_MEM && !bus.mem_ready && !w_timeout)
                r_wait <= r_wait + CW'(1);
            else
                r_wait <= '0;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.pc_src   = 2'b00;
        bus.branch   = 1'b0;
        bus.m        = 1'b0;
        bus.store    = 1'b0;
        bus.ALUOp    = 3'b000;
        bus.ALUSrc   = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemToReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.WriteReg = 3'b000;
        bus.illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.IRWrite = 1'b1;
                if (bus.mem_ready) begin
                    bus.PCWrite = 1'b1;
                    w_next      = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.branch = w_is_branch;
                bus.m      = w_is_branch & r_ir[5];
                bus.store  = w_is_sw;
                if (w_is_jmp) begin
                    bus.PCWrite = 1'b1;
                    bus.pc_src  = 2'b10;
                    w_next      = S_FETCH;
                end else if (w_is_illegal) begin
                    bus.illegal = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.branch = w_is_branch;
                bus.m      = w_is_branch & r_ir[5];
                bus.store  = w_is_sw;
                case (w_op)
                    OP_AND, OP_ANDI:        bus.ALUOp = 3'b000;
                    OP_SUB, OP_BEQ, OP_BNE: bus.ALUOp = 3'b010;
                    default:                bus.ALUOp = 3'b001;
                endcase
                bus.ALUSrc = (w_op == OP_ADDI) | (w_op == OP_ANDI) | w_is_lw | w_is_sw;
                if (w_is_branch) begin
                    bus.PCWrite = w_is_beq ? bus.zero : ~bus.zero;
                    bus.pc_src  = 2'b01;
                    w_next      = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                bus.store = w_is_sw;
                if (w_timeout) begin
                    bus.illegal = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    bus.MemRead  = w_is_lw;
                    bus.MemWrite = w_is_sw;
                    if (bus.mem_ready)
                        w_next = w_is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.WriteReg = r_ir[11:9];
                bus.MemToReg = w_is_lw;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // All strobes must be silent while reset is held, even though the state reads FETCH.
        if (!rst_n) begin
            bus.IRWrite  = 1'b0;
            bus.PCWrite  = 1'b0;
            bus.pc_src   = 2'b00;
            bus.branch   = 1'b0;
            bus.m        = 1'b0;
            bus.store    = 1'b0;
            bus.ALUOp    = 3'b000;
            bus.ALUSrc   = 1'b0;
            bus.MemRead  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.MemToReg = 1'b0;
            bus.RegWrite = 1'b0;
            bus.WriteReg = 3'b000;
            bus.illegal  = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] r_retired;
    logic        w_retire;

    // Only normal completions count; illegal opcodes and timeouts do not.
    assign w_retire = (r_state == S_WB)
                    | (r_state == S_EXEC && w_is_branch)
                    | (r_state == S_DECODE && w_is_jmp)
                    | (r_state == S_MEM && w_is_sw && bus.mem_ready && !w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + 16'd1;
    end

    assign bus.retired = r_retired;
`endif
endmodule
